tpu_mc: RTL and testbench

Parametrised multi-channel timing processing unit: a programmable prescaler produces a slot tick, a slot counter sequences a frame of `FRAME_LEN` slots, and `NCH` independent channels each assert an activity window during their programmed slot. Supports periodic or one-shot channels, per-tick or per-frame maskable interrupt, and runtime-programmable frame length. Sits between the CPU register block and the TX/RX datapath gating, replacing the fixed two-slot (TX/RX) timer.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/tpu_mc_if.sv | 36 +++
 rtl/tpu_prescaler.sv | 37 +++
 rtl/tpu_mc.sv | 100 ++++++++++
 tb/tb_tpu_mc.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and interrupt-select encoding for the timing processing unit
package tpu_pkg;

  localparam int NCH_DEF    = 4;
  localparam int SLOT_W_DEF = 8;
  localparam int TMR_W_DEF  = 16;

  typedef enum logic {
    INT_TICK  = 1'b0,
    INT_FRAME = 1'b1
  } int_sel_e;

endpackage

// File: rtl/tpu_mc_if.sv
// rtl/tpu_mc_if.sv - register-side configuration and status bundle of tpu_mc
interface tpu_mc_if
  import tpu_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int TMR_W  = TMR_W_DEF
) ();

  logic [TMR_W-1:0]      TIMER_INT_VALUE;
  logic [SLOT_W-1:0]     FRAME_LEN;
  logic                  TIMERINTMSK;
  logic                  INT_SEL;
  logic                  INT_CLR;
  logic [NCH-1:0]        CH_EN;
  logic [NCH-1:0]        CH_ONESHOT;
  logic [NCH*SLOT_W-1:0] CH_SLOT;
  logic                  TICK;
  logic                  FRAME_START;
  logic [SLOT_W-1:0]     SLOT_CNT;
  logic [NCH-1:0]        CH_ACTIVE;
  logic                  INTFLAG;

  modport master (
    output TIMER_INT_VALUE, FRAME_LEN, TIMERINTMSK, INT_SEL, INT_CLR,
           CH_EN, CH_ONESHOT, CH_SLOT,
    input  TICK, FRAME_START, SLOT_CNT, CH_ACTIVE, INTFLAG
  );

  modport slave (
    input  TIMER_INT_VALUE, FRAME_LEN, TIMERINTMSK, INT_SEL, INT_CLR,
           CH_EN, CH_ONESHOT, CH_SLOT,
    output TICK, FRAME_START, SLOT_CNT, CH_ACTIVE, INTFLAG
  );

endinterface

// File: rtl/tpu_prescaler.sv
// rtl/tpu_prescaler.sv - reload counter producing a slot-boundary strobe; reload of 0 halts it
module tpu_prescaler
  import tpu_pkg::*;
#(
  parameter int TMR_W = TMR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TMR_W-1:0] reload,
  output logic             tick
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a reload lowered below the running count fires at once
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (reload != '0) begin
      if (cnt_q >= reload - TMR_W'(1)) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tpu_mc.sv
// rtl/tpu_mc.sv - multi-channel slot timer: prescaled tick, frame slot counter, per-channel windows, interrupt
module tpu_mc
  import tpu_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int TMR_W  = TMR_W_DEF
) (
  input logic     SYS_CLK,
  input logic     RSTTPU_N,
  tpu_mc_if.slave bus
);

  logic              tick_en;
  logic [SLOT_W:0]   frame_len_eff;
  logic              tick_q, tick_d;
  logic              frame_start_q, frame_start_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [NCH-1:0]    ch_active_q, ch_active_d;
  logic [NCH-1:0]    armed_q, armed_d;
  logic [NCH-1:0]    hit;
  logic              intflag_q, intflag_d;
  logic              int_event;

  tpu_prescaler #(.TMR_W(TMR_W)) u_prescaler (
    .clk    (SYS_CLK),
    .rst_n  (RSTTPU_N),
    .reload (bus.TIMER_INT_VALUE),
    .tick   (tick_en)
  );

  assign frame_len_eff = (bus.FRAME_LEN == '0) ? {1'b1, {SLOT_W{1'b0}}}
                                               : {1'b0, bus.FRAME_LEN};

  // >= also catches a frame length shrunk below the current slot
  always_comb begin
    tick_d        = tick_en;
    frame_start_d = 1'b0;
    slot_cnt_d    = slot_cnt_q;
    if (tick_en) begin
      if (({1'b0, slot_cnt_q} + (SLOT_W+1)'(1)) >= frame_len_eff) begin
        slot_cnt_d    = '0;
        frame_start_d = 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
      end
    end
  end

  // Compare against the post-increment slot so the window aligns with TICK
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = (armed_q[i] | ~bus.CH_ONESHOT[i]) &
                    (bus.CH_SLOT[i*SLOT_W +: SLOT_W] == slot_cnt_d);
  end

  always_comb begin
    ch_active_d = ch_active_q;
    armed_d     = armed_q;
    for (int i = 0; i < NCH; i++) begin
      if (!bus.CH_EN[i]) begin
        ch_active_d[i] = 1'b0;
        armed_d[i]     = 1'b1;
      end else if (tick_en) begin
        ch_active_d[i] = hit[i];
        armed_d[i]     = ~bus.CH_ONESHOT[i] | (armed_q[i] & ~hit[i]);
      end
    end
  end

  assign int_event = (int_sel_e'(bus.INT_SEL) == INT_FRAME) ? frame_start_q : tick_q;

  always_comb begin
    intflag_d = (int_event & bus.TIMERINTMSK) | (intflag_q & ~bus.INT_CLR);
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RSTTPU_N) begin
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
      slot_cnt_q    <= '0;
      ch_active_q   <= '0;
      armed_q       <= '1;
      intflag_q     <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      frame_start_q <= frame_start_d;
      slot_cnt_q    <= slot_cnt_d;
      ch_active_q   <= ch_active_d;
      armed_q       <= armed_d;
      intflag_q     <= intflag_d;
    end
  end

  assign bus.TICK        = tick_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.SLOT_CNT    = slot_cnt_q;
  assign bus.CH_ACTIVE   = ch_active_q;
  assign bus.INTFLAG     = intflag_q;

endmodule

// File: tb/tb_tpu_mc.sv
// tb/tb_tpu_mc.sv - directed and randomized checks of tpu_mc against a cycle-level reference model
module tb_tpu_mc;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  tpu_mc_if #(.NCH(4), .SLOT_W(8), .TMR_W(16)) bus ();

  tpu_mc #(.NCH(4), .SLOT_W(8), .TMR_W(16)) dut (
    .SYS_CLK  (clk),
    .RSTTPU_N (rstn),
    .bus      (bus)
  );

  int       m_cnt, m_slot;
  bit       m_tick, m_fs, m_flag;
  bit [3:0] m_act, m_armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    int val, len, chs;
    bit ev;
    if (!rstn) begin
      m_cnt = 0; m_slot = 0; m_tick = 0; m_fs = 0; m_flag = 0;
      m_act = '0; m_armed = '1;
    end else begin
      ev     = bus.INT_SEL ? m_fs : m_tick;
      m_flag = (ev && bus.TIMERINTMSK) || (m_flag && !bus.INT_CLR);
      m_tick = 0;
      m_fs   = 0;
      val    = int'(bus.TIMER_INT_VALUE);
      if (val != 0) begin
        if (m_cnt >= val - 1) begin
          m_cnt  = 0;
          m_tick = 1;
        end else begin
          m_cnt++;
        end
      end
      len = (bus.FRAME_LEN == 0) ? 256 : int'(bus.FRAME_LEN);
      if (m_tick) begin
        m_slot++;
        if (m_slot >= len) begin
          m_slot = 0;
          m_fs   = 1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        chs = int'(bus.CH_SLOT[i*8 +: 8]);
        if (!bus.CH_EN[i]) begin
          m_act[i]   = 0;
          m_armed[i] = 1;
        end else if (m_tick) begin
          m_act[i] = (chs == m_slot) && (m_armed[i] || !bus.CH_ONESHOT[i]);
          if (!bus.CH_ONESHOT[i]) m_armed[i] = 1;
          else if (m_act[i])      m_armed[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("tick",        32'(bus.TICK),        32'(m_tick));
    chk("frame_start", 32'(bus.FRAME_START), 32'(m_fs));
    chk("slot_cnt",    32'(bus.SLOT_CNT),    32'(m_slot));
    chk("ch_active",   32'(bus.CH_ACTIVE),   32'(m_act));
    chk("intflag",     32'(bus.INTFLAG),     32'(m_flag));
  endtask

  initial begin
    int  k;
    int  held;
    bit  seen;

    rstn                = 1'b0;
    bus.TIMER_INT_VALUE = 16'd4;
    bus.FRAME_LEN       = 8'd3;
    bus.TIMERINTMSK     = 1'b1;
    bus.INT_SEL         = 1'b1;
    bus.INT_CLR         = 1'b0;
    bus.CH_EN           = 4'b1111;
    bus.CH_ONESHOT      = 4'b0010;
    bus.CH_SLOT         = {8'd2, 8'd2, 8'd1, 8'd0};
    step();
    step();
    chk("reset_slot", 32'(bus.SLOT_CNT), 32'd0);
    chk("reset_act",  32'(bus.CH_ACTIVE), 32'd0);

    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("first_tick_edge", 32'(bus.TICK), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 40; i++) step();

    bus.CH_EN[1] = 1'b0;
    step();
    bus.CH_EN[1] = 1'b1;
    for (int i = 0; i < 30; i++) step();

    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin
      step();
      seen = bus.FRAME_START;
    end
    chk("frame_start_seen", 32'(seen), 32'd1);
    bus.INT_CLR = 1'b1;
    step();
    bus.INT_CLR = 1'b0;
    chk("intflag_after_frame", 32'(bus.INTFLAG), 32'd1);

    bus.TIMERINTMSK = 1'b0;
    bus.INT_CLR     = 1'b1;
    step();
    bus.INT_CLR = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("masked_flag", 32'(bus.INTFLAG), 32'd0);

    bus.TIMER_INT_VALUE = 16'd33000;
    for (k = 0; k < 600 && m_cnt != 500; k++) step();
    chk("reach_cnt500", 32'(m_cnt), 32'd500);
    bus.TIMER_INT_VALUE = 16'd10;
    step();
    chk("lowered_tick", 32'(bus.TICK), 32'd1);
    for (int i = 0; i < 25; i++) step();

    bus.TIMER_INT_VALUE = 16'd0;
    step();
    held = int'(bus.SLOT_CNT);
    for (int i = 0; i < 30; i++) step();
    chk("halt_slot", 32'(bus.SLOT_CNT), 32'(held));

    bus.TIMER_INT_VALUE = 16'd3;
    bus.FRAME_LEN       = 8'd4;
    bus.CH_ONESHOT      = 4'b0000;
    for (k = 0; k < 30 && bus.CH_ACTIVE == 0; k++) step();
    rstn = 1'b0;
    step();
    chk("midreset_act", 32'(bus.CH_ACTIVE), 32'd0);
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("post_reset_tick", 32'(bus.TICK), (i == 3) ? 32'd1 : 32'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) begin
        bus.TIMER_INT_VALUE = 16'($urandom_range(0, 5));
        bus.FRAME_LEN       = 8'($urandom_range(0, 6));
        bus.CH_ONESHOT      = 4'($urandom_range(0, 15));
        bus.INT_SEL         = 1'($urandom_range(0, 1));
        bus.TIMERINTMSK     = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) bus.CH_SLOT[i*8 +: 8] = 8'($urandom_range(0, 6));
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 19) == 0) bus.CH_EN[i] = ~bus.CH_EN[i];
      bus.INT_CLR = ($urandom_range(0, 7) == 0);
      rstn        = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
